// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter: op encodings and FSM states.
// Op codes match the single-step datapath shifter, with 00 taken for rotate-right.
package shift_pkg;

  localparam logic [1:0] SH_ROR = 2'b00;
  localparam logic [1:0] SH_LSL = 2'b01;
  localparam logic [1:0] SH_LSR = 2'b10;
  localparam logic [1:0] SH_ASR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shifter_if.sv
// Start/busy/done handshake between the controller (master) and the shifter (slave).
interface seq_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);

  logic             start;
  logic [1:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport master (
    output start, op, amt, din,
    input  busy, done, dout
  );

  modport slave (
    input  start, op, amt, din,
    output busy, done, dout
  );

endinterface

// File: rtl/shift_step.sv
// One-bit-position shift of the accumulator; purely combinational.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] acc_next
);

  always_comb begin
    case (op)
      SH_ROR:  acc_next = {acc[0], acc[WIDTH-1:1]};
      SH_LSL:  acc_next = {acc[WIDTH-2:0], 1'b0};
      SH_LSR:  acc_next = {1'b0, acc[WIDTH-1:1]};
      default: acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: applies amt single-bit steps to din, one per clock.
//   state   | meaning
//   S_IDLE  | waiting for start; acc holds the last result
//   S_SHIFT | stepping acc once per cycle while cnt counts down to 1
//   S_DONE  | one-cycle done pulse, result on dout
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  seq_shifter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_step;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .op       (op_q),
    .acc_next (acc_step)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.din;
          op_d    = bus.op;
          cnt_d   = bus.amt;
          state_d = (bus.amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= SH_ROR;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Outputs decode registers only, so there is no input-to-output path.
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.dout = acc_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed vectors plus a cycle-timeline model.
module tb_seq_shifter;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;

  seq_shifter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) sif ();

  seq_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-operation result from the arithmetic definition of each shift.
  function automatic logic [15:0] ref_shift(input logic [1:0] o, input int a, input logic [15:0] x);
    logic [31:0]        dbl;
    logic signed [15:0] sx;
    logic [15:0]        r;
    dbl = {x, x};
    sx  = x;
    case (o)
      2'b00:   r = 16'(dbl >> (a % 16));
      2'b01:   r = 16'({16'h0, x} << a);
      2'b10:   r = x >> a;
      default: r = 16'(sx >>> a);
    endcase
    return r;
  endfunction

  // Timeline model: an accepted start at the end of cycle k makes the
  // unit busy through cycle k+amt+1, pulsing done in that last cycle.
  logic        m_init;
  logic        m_active;
  logic        m_valid;
  logic [15:0] m_result;
  int          m_done_at;
  logic        prev_done;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_init   <= 1'b1;
      m_active <= 1'b0;
      m_valid  <= 1'b1;
      m_result <= 16'h0;
    end else if (m_init && !m_active && sif.start) begin
      m_active  <= 1'b1;
      m_done_at <= cyc + 1 + int'(sif.amt);
      m_result  <= ref_shift(sif.op, int'(sif.amt), sif.din);
      m_valid   <= (sif.amt == '0);
    end else if (m_active && (cyc + 1 == m_done_at)) begin
      m_valid <= 1'b1;
    end else if (m_active && (cyc == m_done_at)) begin
      m_active <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_init && !reset) begin
      chk("busy", {31'h0, sif.busy}, {31'h0, m_active});
      chk("done", {31'h0, sif.done}, {31'h0, (m_active && cyc == m_done_at)});
      if (m_valid) chk("dout", {16'h0, sif.dout}, {16'h0, m_result});
      if (sif.done) chk("done_not_consecutive", {31'h0, prev_done}, 32'h0);
    end
    prev_done <= sif.done;
  end

  task automatic run(input string name, input logic [1:0] o, input logic [3:0] a,
                     input logic [15:0] d, input logic [15:0] exp, input int exp_lat,
                     input int hold);
    int  t0;
    bit  got;
    @(posedge clk);
    #2;
    sif.start = 1'b1;
    sif.op    = o;
    sif.amt   = a;
    sif.din   = d;
    t0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sif.done) begin
        got = 1'b1;
        chk({name, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
        chk({name, "_dout"}, {16'h0, sif.dout}, {16'h0, exp});
      end else begin
        if (i >= 1 && i < hold) begin
          sif.din = 16'(16'h1111 * (i + 1));
          sif.op  = ~o;
          sif.amt = ~a;
        end
        if (i >= hold) sif.start = 1'b0;
      end
    end
    sif.start = 1'b0;
    if (!got) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic reset_mid_shift();
    int pulses;
    @(posedge clk);
    #2;
    sif.start = 1'b1;
    sif.op    = 2'b01;
    sif.amt   = 4'd8;
    sif.din   = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", {31'h0, sif.busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'h0, sif.busy}, 32'h0);
    chk("rst_done", {31'h0, sif.done}, 32'h0);
    chk("rst_dout", {16'h0, sif.dout}, 32'h0);
    reset  = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (sif.done) pulses++;
    end
    chk("rst_no_done_pulse", 32'(pulses), 32'h0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    m_init    = 1'b0;
    m_active  = 1'b0;
    m_valid   = 1'b0;
    m_result  = 16'h0;
    m_done_at = -1;
    prev_done = 1'b0;
    reset     = 1'b1;
    sif.start = 1'b0;
    sif.op    = 2'b00;
    sif.amt   = '0;
    sif.din   = '0;

    chk("model_ror", {16'h0, ref_shift(2'b00, 4, 16'h1234)}, 32'h4123);
    chk("model_asr", {16'h0, ref_shift(2'b11, 3, 16'h8001)}, 32'hF000);
    chk("model_lsl", {16'h0, ref_shift(2'b01, 4, 16'h8001)}, 32'h0010);

    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'h0, sif.busy}, 32'h0);
    chk("reset_done", {31'h0, sif.done}, 32'h0);
    chk("reset_dout", {16'h0, sif.dout}, 32'h0);

    run("asr_pass", 2'b11, 4'd0,  16'hABCD, 16'hABCD, 1,  1);
    run("lsr_3",    2'b10, 4'd3,  16'h8001, 16'h1000, 4,  1);
    run("asr_3",    2'b11, 4'd3,  16'h8001, 16'hF000, 4,  1);
    run("lsl_4",    2'b01, 4'd4,  16'h8001, 16'h0010, 5,  1);
    run("lsl_15",   2'b01, 4'd15, 16'h0001, 16'h8000, 16, 1);
    run("asr_15",   2'b11, 4'd15, 16'h8000, 16'hFFFF, 16, 1);
    run("ror_4",    2'b00, 4'd4,  16'h1234, 16'h4123, 5,  1);
    run("ror_1",    2'b00, 4'd1,  16'h8001, 16'hC000, 2,  1);
    run("held_lsr", 2'b10, 4'd2,  16'hF000, 16'h3C00, 3,  4);
    run("b2b_lsl",  2'b01, 4'd1,  16'h00FF, 16'h01FE, 2,  1);
    repeat (4) @(negedge clk);
    reset_mid_shift();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Multi-cycle shift unit that applies an arbitrary shift amount (0..2^AMT_W-1) to a WIDTH-bit operand, one bit position per clock.
- Reuses the datapath's single-bit shift encodings (01 LSL, 10 LSR, 11 ASR) and adds rotate-right (00).
- Sits beside the single-step datapath shifter. Used by the controller for shift-by-register instructions, via a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits
AMT_W, 4, shift-amount width; maximum shift is 2^AMT_W-1

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  00 ROR, 01 LSL, 10 LSR, 11 ASR
amt  in  AMT_W  shift amount, sampled with start
din  in  WIDTH  operand, sampled with start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse: result valid on dout
dout  out  WIDTH  accumulator contents

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- On reset: state=IDLE, acc=0, cnt=0, op_q=00, busy=0, done=0, dout=0.
- Reset is honoured in any state, including mid-shift. The operation in flight is discarded and no done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - acc<=din, op_q<=op, cnt<=amt.
  - amt==0: next state DONE (pass-through).
  - otherwise: next state SHIFT.
- IDLE, start=0: hold all registers.
- SHIFT, each cycle: acc<=step(acc,op_q), cnt<=cnt-1. When cnt==1, next state DONE.
- DONE: done=1 for exactly this cycle, then next state IDLE unconditionally.
- Step function, one bit per cycle:
  - ROR: {acc[0],acc[W-1:1]}
  - LSL: {acc[W-2:0],0}
  - LSR: {0,acc[W-1:1]}
  - ASR: {acc[W-1],acc[W-1:1]}
- Latency: start accepted in cycle 0 gives done in cycle amt+1. Examples: amt=0 gives cycle 1; amt=15 gives cycle 16.
- Throughput: the next start is accepted no earlier than cycle amt+2.
- start while busy (SHIFT or DONE) is ignored; no queuing. din, op and amt changes while busy have no effect.
- dout is driven directly from acc:
  - while SHIFT: shows intermediate values, which consumers must ignore;
  - from the done cycle until the next accepted start: holds the final result.
- busy and done are combinational decodes of the state register only; no input-to-output combinational path.
- Shift amount is not reduced modulo WIDTH: AMT_W bounds it. For LSL/LSR with amt>=WIDTH (only possible if AMT_W is enlarged) the result is 0; ASR gives all sign bits.

Decomposition:
- Package shift_pkg holds:
  - op encoding constants SH_ROR=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11;
  - FSM state enum {S_IDLE,S_SHIFT,S_DONE}.
- Sub-module shift_step: purely combinational, parameterised by WIDTH. Inputs (acc, op), output the next acc per the step function. It is instantiated once. The FSM, counter and accumulator stay in seq_shifter.

Test Plan:
- Reset: assert reset during SHIFT of LSL 0x0001 by 8 -> next cycle busy=0, done=0, dout=0x0000, and no done pulse afterwards.
- Pass-through: start, op=ASR, amt=0, din=0xABCD -> done in cycle 1, dout=0xABCD, busy high only in cycle 1.
- Right shifts, din=0x8001, amt=3:
  - LSR -> done in cycle 4, dout=0x1000;
  - ASR -> dout=0xF000.
- Left and max-amount cases:
  - LSL 0x8001 by 4 -> dout=0x0010, done in cycle 5;
  - LSL 0x0001 by 15 -> dout=0x8000, done in cycle 16;
  - ASR 0x8000 by 15 -> dout=0xFFFF.
- Rotate: ROR 0x1234 by 4 -> dout=0x4123; ROR 0x8001 by 1 -> dout=0xC000, done in cycle 2.
- Handshake: hold start=1 with changing din across a LSR 0xF000 by 2 -> only the first request is processed (dout=0x3C00 at done). A new start is accepted in the cycle after done. done is never high two consecutive cycles.
